fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 159 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream FIFO (1-cycle read latency).
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
//
// Ports:
//   i_Clk        system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Enable     permits new frames to start (sampled only in IDLE)
//   i_FIFO_Empty upstream FIFO empty flag (sampled only in IDLE)
//   i_FIFO_Data  upstream FIFO read data
//   o_FIFO_Rd    one-cycle read strobe, one per frame
//   o_Tx_Serial  UART line, idle high
//   o_Tx_Active  high from the read strobe through the last stop-bit clock
//   o_Tx_Done    one-cycle pulse on the last stop-bit clock
module fifo_uart_tx #(
  parameter int g_DATA_SIZE    = 8,
  parameter int g_CLKS_PER_BIT = 868
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic                   i_FIFO_Empty,
  input  logic [g_DATA_SIZE-1:0] i_FIFO_Data,
  output logic                   o_FIFO_Rd,
  output logic                   o_Tx_Serial,
  output logic                   o_Tx_Active,
  output logic                   o_Tx_Done
);

  localparam int CNT_W = $clog2(g_CLKS_PER_BIT);
  localparam int IDX_W =
    (g_DATA_SIZE > 1) ? $clog2(g_DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(g_CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(g_DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [g_DATA_SIZE-1:0] shift_q, shift_d;
  logic                   serial_q, serial_d;
  logic                   rd_q, rd_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   bit_end;
  logic                   in_frame;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign in_frame = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);

  // Next-state, counters and shift register
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = '0;
    if (in_frame && !bit_end) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (i_Enable && !i_FIFO_Empty) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = LOAD;
      LOAD: begin
        shift_d = i_FIFO_Data;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they
  // line up cycle-for-cycle with the registered state.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[idx_d];
      PARITY:  serial_d = ^shift_d;
      default: serial_d = 1'b1;
    endcase
    rd_d     = (state_d == RD_REQ);
    active_d = (state_d != IDLE);
    done_d   = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      rd_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      rd_q     <= rd_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_FIFO_Rd   = rd_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model plus frame-level line model.
// Covers reset, idle-empty, back-to-back frames, enable drop, mid-frame reset.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Enable = 1'b0;
  logic          i_FIFO_Empty = 1'b1;
  logic [DW-1:0] i_FIFO_Data = '0;
  logic          o_FIFO_Rd;
  logic          o_Tx_Serial;
  logic          o_Tx_Active;
  logic          o_Tx_Done;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .g_DATA_SIZE   (DW),
    .g_CLKS_PER_BIT(CPB)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (i_Reset),
    .i_Enable    (i_Enable),
    .i_FIFO_Empty(i_FIFO_Empty),
    .i_FIFO_Data (i_FIFO_Data),
    .o_FIFO_Rd   (o_FIFO_Rd),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Done   (o_Tx_Done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock; FIFO answers a read with registered latency.
  task automatic step();
    logic rd_prev;
    rd_prev = o_FIFO_Rd;
    @(posedge clk);
    #1;
    if (rd_prev === 1'b1 && fifo_q.size() > 0)
      i_FIFO_Data = fifo_q.pop_front();
    i_FIFO_Empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    i_FIFO_Empty = 1'b0;
  endtask

  // Line value for bit slot j of a frame carrying b.
  function automatic logic frame_bit(input logic [DW-1:0] b,
                                     input int j);
    if (j == 0) return 1'b0;
    if (j <= DW) return b[j-1];
    if (j == DW + 1 && FRAME_BITS == DW + 3) return ^b;
    return 1'b1;
  endfunction

  // Follows one frame from its read strobe. exp_gap<0 skips
  // the gap check; drop_at drops i_Enable at that frame cycle;
  // cut_at returns at that frame cycle (caller continues).
  task automatic run_frame(input logic [DW-1:0] b,
                           input int exp_gap,
                           input int drop_at,
                           input int cut_at);
    int wait_n;
    wait_n = 0;
    while (o_FIFO_Rd !== 1'b1 && wait_n < 200) begin
      chk("idle_line", o_Tx_Serial, 1);
      chk("idle_active", o_Tx_Active, 0);
      step();
      wait_n++;
    end
    chk("rd_seen", o_FIFO_Rd, 1);
    if (exp_gap >= 0) chk("frame_gap", wait_n, exp_gap);
    for (int p = 0; p < 3; p++) begin
      chk("pre_line", o_Tx_Serial, 1);
      chk("pre_active", o_Tx_Active, 1);
      chk("pre_rd", o_FIFO_Rd, (p == 0) ? 1 : 0);
      chk("pre_done", o_Tx_Done, 0);
      step();
    end
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      chk("line", o_Tx_Serial, frame_bit(b, i / CPB));
      chk("active", o_Tx_Active, 1);
      chk("rd_quiet", o_FIFO_Rd, 0);
      chk("done",
          o_Tx_Done, (i == FRAME_BITS * CPB - 1) ? 1 : 0);
      if (i == drop_at) i_Enable = 1'b0;
      if (i == cut_at) return;
      step();
    end
  endtask

  initial begin
    logic [DW-1:0] rb;

    // Reset state
    i_Reset = 1'b1;
    repeat (3) step();
    chk("rst_line", o_Tx_Serial, 1);
    chk("rst_rd", o_FIFO_Rd, 0);
    chk("rst_active", o_Tx_Active, 0);
    chk("rst_done", o_Tx_Done, 0);
    i_Reset = 1'b0;
    step();

    // Enabled but empty: nothing happens
    i_Enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("empty_rd", o_FIFO_Rd, 0);
      chk("empty_line", o_Tx_Serial, 1);
      step();
    end

    // Directed 0xA5 frame, then 0x07 back to back
    push(8'hA5);
    push(8'h07);
    run_frame(8'hA5, -1, -1, -1);
    run_frame(8'h07, 1, -1, -1);

    // Random back-to-back frames
    for (int n = 0; n < 6; n++) begin
      rb = DW'($urandom_range(0, 255));
      push(rb);
    end
    for (int n = 0; n < 6; n++) begin
      rb = fifo_q[0];
      run_frame(rb, (n == 0) ? -1 : 1, -1, -1);
    end
    chk("drained", fifo_q.size(), 0);

    // Enable dropped during data bit 3: frame completes, stops
    push(8'h3C);
    push(8'h11);
    push(8'h5A);
    run_frame(8'h3C, -1, CPB * 4, -1);
    for (int i = 0; i < 30; i++) begin
      chk("hold_rd", o_FIFO_Rd, 0);
      chk("hold_line", o_Tx_Serial, 1);
      step();
    end
    chk("hold_left", fifo_q.size(), 2);

    // Reset during data bit 5 aborts 0x11; 0x5A goes next
    i_Enable = 1'b1;
    run_frame(8'h11, -1, -1, CPB * 6);
    i_Reset = 1'b1;
    step();
    chk("abort_line", o_Tx_Serial, 1);
    chk("abort_active", o_Tx_Active, 0);
    chk("abort_rd", o_FIFO_Rd, 0);
    chk("abort_done", o_Tx_Done, 0);
    i_Reset = 1'b0;
    run_frame(8'h5A, 1, -1, -1);
    chk("final_empty", fifo_q.size(), 0);
    repeat (5) begin
      chk("end_line", o_Tx_Serial, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
